// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown sequencer.
//   state_e     : controller FSM state enumeration and encoding
//   CNT_RST_VAL : value the count and reload registers take on reset
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned CNT_RST_VAL = 0;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter used as the countdown datapath.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   load     : load load_val this edge (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one this edge; saturates at zero
//   count    : registered count value
//   zero     : count is zero
module down_counter
  import countdown_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic             dec,
  output logic [NBITS-1:0] count,
  output logic             zero
);

  logic [NBITS-1:0] count_q;
  logic [NBITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - NBITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= NBITS'(CNT_RST_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/countdown_seq_ctrl.sv
// Countdown sequencer: start loads a value, the count runs down to zero,
// then either reloads (auto-reload) or parks in DONE.
//   clk         : clock, rising edge
//   rst         : synchronous active-low reset
//   start       : launch a countdown (ignored while busy)
//   load_val    : start value, captured on an accepted start
//   auto_reload : reload mode, captured on an accepted start
//   hold        : freeze the countdown while high
//   abort       : return to IDLE with count cleared
//   count       : current count
//   busy        : high in RUN
//   tc_pulse    : one-cycle strobe on the edge the count reaches zero
//   done        : high in DONE
module countdown_seq_ctrl
  import countdown_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] load_val,
  input  logic             auto_reload,
  input  logic             hold,
  input  logic             abort,
  output logic [NBITS-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  state_e           state_q, state_d;
  logic [NBITS-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  // Set when a countdown was launched from zero and its single terminal
  // strobe has not yet been emitted.
  logic             zero_pend_q, zero_pend_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic [NBITS-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [NBITS-1:0] cnt_val;
  logic             cnt_zero;

  down_counter #(.NBITS(NBITS)) u_down_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    mode_d       = mode_q;
    zero_pend_d  = zero_pend_q;
    tc_d         = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = reload_q;
    cnt_dec      = 1'b0;

    if (abort) begin
      state_d      = ST_IDLE;
      zero_pend_d  = 1'b0;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d      = ST_RUN;
            reload_d     = load_val;
            mode_d       = auto_reload;
            zero_pend_d  = (load_val == '0);
            cnt_load     = 1'b1;
            cnt_load_val = load_val;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            if (!cnt_zero) begin
              cnt_dec = 1'b1;
              tc_d    = (cnt_val == NBITS'(1));
            end else if (zero_pend_q) begin
              // Zero load: strobe once, then finish on the following edge.
              tc_d        = 1'b1;
              zero_pend_d = 1'b0;
            end else if (mode_q && (reload_q != '0)) begin
              cnt_load     = 1'b1;
              cnt_load_val = reload_q;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      reload_q    <= NBITS'(CNT_RST_VAL);
      mode_q      <= 1'b0;
      zero_pend_q <= 1'b0;
      tc_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      zero_pend_q <= zero_pend_d;
      tc_q        <= tc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign count    = cnt_val;
  assign busy     = busy_q;
  assign tc_pulse = tc_q;
  assign done     = done_q;

endmodule
